// File: rtl/rptr_empty_if.sv
// rtl/rptr_empty_if.sv - read-side pointer bundle of an async FIFO; level signals exist only under RPTR_EMPTY_LEVEL_EN
interface rptr_empty_if #(
  parameter int ASIZE = 4
);
  logic             rinc;
  logic [ASIZE:0]   rq2_wptr;
  logic             rempty;
  logic [ASIZE-1:0] raddr;
  logic [ASIZE:0]   rptr;
`ifdef RPTR_EMPTY_LEVEL_EN
  logic             raempty;
  logic [ASIZE:0]   rlevel;

  modport master (
    output rinc, rq2_wptr,
    input  rempty, raddr, rptr, raempty, rlevel
  );
  modport slave (
    input  rinc, rq2_wptr,
    output rempty, raddr, rptr, raempty, rlevel
  );
`else
  modport master (
    output rinc, rq2_wptr,
    input  rempty, raddr, rptr
  );
  modport slave (
    input  rinc, rq2_wptr,
    output rempty, raddr, rptr
  );
`endif
endinterface

// File: rtl/rptr_empty.sv
// rtl/rptr_empty.sv - async FIFO read pointer, Gray rptr and registered empty flag
// Optional almost-empty/level outputs are built when RPTR_EMPTY_LEVEL_EN is defined.
module rptr_empty #(
  parameter int ASIZE         = 4,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic       rclk,
  input  logic       rrst,
  rptr_empty_if.slave bus
);

  logic [ASIZE:0] rbin;
  logic [ASIZE:0] rbinnext;
  logic [ASIZE:0] rgraynext;
  logic [ASIZE:0] rptr_q;
  logic           rempty_q;
  logic           pop;

  // A pop is only honoured while the FIFO is not empty (underflow protection).
  assign pop       = bus.rinc & ~rempty_q;
  assign rbinnext  = rbin + {{ASIZE{1'b0}}, pop};
  assign rgraynext = rbinnext ^ (rbinnext >> 1);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin     <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
    end else begin
      rbin     <= rbinnext;
      rptr_q   <= rgraynext;
      rempty_q <= (rgraynext == bus.rq2_wptr);
    end
  end

  assign bus.raddr  = rbin[ASIZE-1:0];
  assign bus.rptr   = rptr_q;
  assign bus.rempty = rempty_q;

`ifdef RPTR_EMPTY_LEVEL_EN
  localparam logic [ASIZE:0] AE_THRESH = (ASIZE+1)'(AEMPTY_THRESH);

  logic [ASIZE:0] wbin;
  logic [ASIZE:0] level_next;
  logic [ASIZE:0] rlevel_q;
  logic           raempty_q;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ASIZE; i++) begin
      wbin[i] = ^(bus.rq2_wptr >> i);
    end
  end

  assign level_next = wbin - rbinnext;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rlevel_q  <= '0;
      raempty_q <= 1'b1;
    end else begin
      rlevel_q  <= level_next;
      raempty_q <= (level_next <= AE_THRESH);
    end
  end

  assign bus.rlevel  = rlevel_q;
  assign bus.raempty = raempty_q;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// tb/tb_rptr_empty.sv - bench for rptr_empty against a read/write-count occupancy model
module tb_rptr_empty;
  logic rclk = 1'b0;
  logic rrst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Model state: absolute read and write counts, plus registered expectations.
  int   rcount = 0;
  int   wcount = 0;
  logic m_empty = 1'b1;
  int   m_level = 0;
  logic [4:0] prev_rptr = '0;

  rptr_empty_if #(.ASIZE(4)) bus ();

  rptr_empty #(.ASIZE(4), .AEMPTY_THRESH(1)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray5(input int count);
    int v;
    logic [4:0] b;
    v = count & 31;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rempty", 32'(bus.rempty), 32'(m_empty));
    check("rptr", 32'(bus.rptr), 32'(gray5(rcount)));
    check("raddr", 32'(bus.raddr), 32'(rcount & 15));
    check("gray_1bit", 32'($countones(bus.rptr ^ prev_rptr) <= 1), 32'd1);
`ifdef RPTR_EMPTY_LEVEL_EN
    check("rlevel", 32'(bus.rlevel), 32'(m_level));
    check("raempty", 32'(bus.raempty), 32'(m_level <= 1));
`endif
    prev_rptr = bus.rptr;
  endtask

  // One rclk cycle: present inputs mid-cycle, advance the model on the edge, check after it.
  task automatic step(input logic inc, input int wc);
    @(negedge rclk);
    bus.rinc     = inc;
    wcount       = wc;
    bus.rq2_wptr = gray5(wc);
    @(posedge rclk);
    if (inc && !m_empty) rcount++;
    m_level = (wcount - rcount) & 31;
    m_empty = (m_level == 0);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge rclk);
    #2;
    rrst = 1'b1;
    #1;
    rcount = 0; wcount = 0; m_empty = 1'b1; m_level = 0; prev_rptr = '0;
    check("rst_rempty", 32'(bus.rempty), 32'd1);
    check("rst_rptr", 32'(bus.rptr), 32'd0);
    check("rst_raddr", 32'(bus.raddr), 32'd0);
`ifdef RPTR_EMPTY_LEVEL_EN
    check("rst_raempty", 32'(bus.raempty), 32'd1);
    check("rst_rlevel", 32'(bus.rlevel), 32'd0);
`endif
    bus.rinc = 1'b0;
    bus.rq2_wptr = '0;
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  initial begin
    bus.rinc = 1'b0;
    bus.rq2_wptr = '0;
    do_reset();

    // Three entries visible, then one pop.
    step(1'b0, 3);
    check("d26_rempty", 32'(bus.rempty), 32'd0);
    step(1'b1, 3);
    check("d26_raddr", 32'(bus.raddr), 32'd1);
    check("d26_rptr", 32'(bus.rptr), 32'b00001);
`ifdef RPTR_EMPTY_LEVEL_EN
    check("d26_rlevel", 32'(bus.rlevel), 32'd2);
`endif

    // Single entry, rinc held: empty on the popping edge, then pops ignored.
    do_reset();
    step(1'b1, 1);
    step(1'b1, 1);
    check("d27_rempty", 32'(bus.rempty), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1);
    check("d27_rptr", 32'(bus.rptr), 32'b00001);
    check("d27_raddr", 32'(bus.raddr), 32'd1);

    // Level 1 with a write landing on the popping edge keeps the FIFO non-empty.
    step(1'b0, 2);
    step(1'b1, 3);
    check("d29_rempty", 32'(bus.rempty), 32'd0);
`ifdef RPTR_EMPTY_LEVEL_EN
    check("d29_rlevel", 32'(bus.rlevel), 32'd1);
`endif

    // Reset with a pop pending must discard it.
    step(1'b0, 6);
    @(negedge rclk);
    bus.rinc = 1'b1;
    do_reset();
    step(1'b0, 0);

    // Stream 33 entries so both pointers wrap.
    do_reset();
    begin
      int w;
      w = 0;
      for (int i = 0; i < 45; i++) begin
        if (w < 33 && (w - rcount) < 16) w++;
        step(1'b1, w);
      end
    end
    check("d28_rcount", 32'(rcount), 32'd33);
    check("d28_raddr", 32'(bus.raddr), 32'd1);

    // Random traffic against the occupancy model.
    do_reset();
    begin
      int w;
      w = 0;
      for (int i = 0; i < 400; i++) begin
        if ((w - rcount) < 16 && ($urandom % 2) == 0) w++;
        step(1'(($urandom % 3) != 0), w);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 Parameter ASIZE, default 4: FIFO address width; depth is 2^ASIZE.
REQ-002 Parameter AEMPTY_THRESH, default 1: almost-empty level threshold, range 0..2^ASIZE.
REQ-003 rclk  in  1  read-domain clock; the only clock.
REQ-004 rrst  in  1  asynchronous, active-high reset.
REQ-005 rinc  in  1  read request; pops one entry when not empty.
REQ-006 rq2_wptr  in  ASIZE+1  Gray write pointer, already synchronized into rclk.
REQ-007 rempty  out  1  FIFO empty, registered.
REQ-008 raddr  out  ASIZE  binary RAM read address.
REQ-009 rptr  out  ASIZE+1  registered Gray read pointer, sent to the write-domain synchronizer.
REQ-010 raempty  out  1  almost-empty, registered; present only with RPTR_EMPTY_LEVEL_EN.
REQ-011 rlevel  out  ASIZE+1  occupancy as seen by the read side, registered; present only with RPTR_EMPTY_LEVEL_EN.

Function
REQ-012 Internal binary counter rbin (ASIZE+1 bits) SHALL advance by one per rclk when rinc=1 and rempty=0.
- rbinnext = rbin + (rinc AND NOT rempty).
REQ-013 rinc while rempty=1 SHALL be ignored: no change to rbin, rptr or raddr (underflow protection).
REQ-014 rgraynext SHALL be rbinnext XOR (rbinnext >> 1).
- rptr SHALL register rgraynext every rclk.
- rptr SHALL change in at most one bit per cycle.
REQ-015 raddr SHALL equal rbin[ASIZE-1:0] of the registered counter; zero combinational depth from rinc.
REQ-016 rempty SHALL register (rgraynext == rq2_wptr) every rclk.
- rq2_wptr is sampled as presented in that same cycle, including the cycle of a pop.
REQ-017 Latency: rempty SHALL deassert on the first rclk edge after rq2_wptr differs from rptr; it SHALL assert on the same edge that pops the last entry.
REQ-018 Wrap-around:
- rbin SHALL roll from 2^(ASIZE+1)-1 to 0.
- raddr SHALL roll from 2^ASIZE-1 to 0.
- rptr SHALL follow the Gray sequence through the wrap; the MSB distinguishes laps.
REQ-019 rempty is pessimistic: a stale rq2_wptr SHALL only delay deassertion, never deassert rempty falsely.

Reset
REQ-020 rrst=1 SHALL force, without a clock edge: rbin=0, rptr=0, raddr=0, rempty=1; and, with the macro, raempty=1 and rlevel=0.
REQ-021 Reset assertion mid-operation SHALL discard any in-flight pop.
REQ-022 Reset release SHALL be taken synchronously by the integrator; the first pop is possible on the second rclk edge after release, once rq2_wptr is non-zero.

Configuration
REQ-023 Macro RPTR_EMPTY_LEVEL_EN defined: the block SHALL include Gray-to-binary conversion of rq2_wptr (wbin).
- rlevel SHALL register (wbin - rbinnext) mod 2^(ASIZE+1).
- raempty SHALL register (that value <= AEMPTY_THRESH).
REQ-024 Macro RPTR_EMPTY_LEVEL_EN not defined: raempty and rlevel ports and their logic SHALL be absent; all other behaviour is identical.

Verification (ASIZE=4, AEMPTY_THRESH=1, macro defined unless stated)
REQ-025 Assert rrst asynchronously between edges -> immediately rempty=1, raempty=1, rptr=00000, raddr=0, rlevel=0.
REQ-026 rq2_wptr=00010 (gray 3), rinc=0 -> next edge rempty=0, rlevel=3, raempty=0; one pop -> raddr 0->1, rptr=00001, rlevel=2.
REQ-027 rq2_wptr=00001 (gray 1), rinc held high -> one pop -> rempty=1 and raempty=1 on the same edge; further rinc leaves rptr=00001 and raddr=1.
REQ-028 Stream 31 entries then 2 more (wptr wrapping) -> rbin 31->0, rptr 10000->00000, raddr 15->0; rempty=1 exactly when rptr==rq2_wptr; rptr never changes more than one bit per edge (checker).
REQ-029 rq2_wptr advances by one on the same edge as a pop at level 1 -> rempty stays 0 and rlevel=1.
REQ-030 Macro undefined build -> raempty/rlevel absent; REQ-025..028 rempty, rptr and raddr results unchanged.
